// File: rtl/arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, read owner tags.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, LOCK, YIELD} arb_state_e;

  typedef enum logic {OWN_CPU, OWN_CP} owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep shift pipe carrying the owner of each granted read so the
// returning data can be steered to the requester that issued it.
module rd_tag_pipe
  import arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t pipe_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the CPU MEM stage and the
// image coprocessor DMA, with bounded coprocessor bursts and anti-starvation.
module dmem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RD_LAT       = 1,
  parameter int MAX_BURST    = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              cp_req,
  input  logic              cp_we,
  input  logic              cp_last,
  input  logic [ADDR_W-1:0] cp_addr,
  input  logic [DATA_W-1:0] cp_wdata,
  output logic              cp_gnt,
  output logic              cp_rvalid,
  output logic [DATA_W-1:0] cp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e    state_q, state_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          cpu_gnt, starved;
  rd_tag_t       tag_in, tag_out;

  assign starved = (starve_cnt_q == STARVE_MAX);

  // Grants are combinational so a winning requester is served the same cycle.
  always_comb begin
    cpu_gnt = 1'b0;
    cp_gnt  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (cp_req && starved) cp_gnt  = 1'b1;
          else if (cpu_req)      cpu_gnt = 1'b1;
          else                   cp_gnt  = cp_req;
        end
        LOCK:    cp_gnt  = cp_req;
        YIELD:   cpu_gnt = cpu_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cp_gnt && !cp_last) begin
          state_d     = LOCK;
          burst_cnt_d = BW'(1);
        end
      end
      LOCK: begin
        // cp_last takes priority over the burst limit on the same beat.
        if (cp_gnt) begin
          if (cp_last) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
          end else if (burst_cnt_q == BURST_LAST) begin
            state_d     = YIELD;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + BW'(1);
          end
        end
      end
      YIELD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_cnt_d = '0;
    if (cp_req && !cp_gnt) starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign cpu_stall = !rst && cpu_req && !cpu_gnt;
  assign mem_en    = cpu_gnt || cp_gnt;
  assign mem_we    = (cpu_gnt && cpu_we) || (cp_gnt && cp_we);
  assign mem_addr  = cp_gnt ? cp_addr  : cpu_addr;
  assign mem_wdata = cp_gnt ? cp_wdata : cpu_wdata;

  assign tag_in.valid = (cpu_gnt && !cpu_we) || (cp_gnt && !cp_we);
  assign tag_in.owner = cp_gnt ? OWN_CP : OWN_CPU;

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign cpu_rvalid = !rst && tag_out.valid && (tag_out.owner == OWN_CPU);
  assign cp_rvalid  = !rst && tag_out.valid && (tag_out.owner == OWN_CP);
  assign cpu_rdata  = mem_rdata;
  assign cp_rdata   = mem_rdata;

endmodule
